// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helper for the AES key expander.
package aes_pkg;

    localparam int         NUM_KEYS_MAX    = 15;
    localparam logic       AES_128_BIT_KEY = 1'b0;
    localparam logic       AES_256_BIT_KEY = 1'b1;
    localparam logic [3:0] AES128_ROUNDS   = 4'ha;
    localparam logic [3:0] AES256_ROUNDS   = 4'he;
    localparam logic [7:0] RCON_INIT       = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_INIT = 2'b01,
        ST_GEN  = 2'b10
    } kx_state_e;

    // Multiply by x in GF(2^8), reduced with the AES polynomial.
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-expander bus: cipher key in, round keys out, shared S-box word port.
interface aes_key_expander_if;

    logic [255:0] key;
    logic         keylen;
    logic         init;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;

    modport master (
        output key, keylen, init, round, new_sboxw,
        input  round_key, ready, sboxw
    );

    modport slave (
        input  key, keylen, init, round, new_sboxw,
        output round_key, ready, sboxw
    );

endinterface

// File: rtl/aes_key_step.sv
// Combinational next-round-key computation for AES-128 and AES-256 schedules.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] prev,
    input  logic [127:0] prev2,
    input  logic [31:0]  new_sboxw,
    input  logic [7:0]   rcon,
    input  logic         keylen,
    input  logic         odd_idx,
    output logic [127:0] next_key,
    output logic [31:0]  sboxw,
    output logic         rot_sel
);

    logic [127:0] base_s;
    logic [31:0]  t_s;
    logic [31:0]  temp_s;
    logic [31:0]  w0_s;
    logic [31:0]  w1_s;
    logic [31:0]  w2_s;
    logic [31:0]  w3_s;

    // AES-256 odd steps substitute without rotation or rcon and chain onto the key two back.
    always_comb begin
        rot_sel  = (keylen == AES_128_BIT_KEY) ? 1'b1 : ~odd_idx;
        base_s   = (keylen == AES_128_BIT_KEY) ? prev : prev2;
        t_s      = prev[31:0];
        sboxw    = rot_sel ? {t_s[23:0], t_s[31:24]} : t_s;
        temp_s   = new_sboxw ^ (rot_sel ? {rcon, 24'h000000} : 32'h0000_0000);
        w0_s     = base_s[127:96] ^ temp_s;
        w1_s     = base_s[95:64]  ^ w0_s;
        w2_s     = base_s[63:32]  ^ w1_s;
        w3_s     = base_s[31:0]   ^ w2_s;
        next_key = {w0_s, w1_s, w2_s, w3_s};
    end

endmodule

// File: rtl/aes_key_expander.sv
// AES-128/256 key expander: one round key per cycle into a 15-entry store read by round index.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NUM_KEYS = NUM_KEYS_MAX
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_key_expander_if.slave    bus
);

    kx_state_e    state_q, state_d;
    logic         ready_q, ready_d;
    logic         keylen_q, keylen_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] keys_q [NUM_KEYS];
    logic [127:0] keys_d [NUM_KEYS];

    logic [3:0]   prev_idx_s;
    logic [3:0]   prev2_idx_s;
    logic [3:0]   last_idx_s;
    logic [127:0] prev_s;
    logic [127:0] prev2_s;
    logic [127:0] rk_s;
    logic [127:0] next_key_s;
    logic [31:0]  step_sboxw_s;
    logic         rot_sel_s;

    assign prev_idx_s  = cnt_q - 4'd1;
    assign prev2_idx_s = cnt_q - 4'd2;
    assign last_idx_s  = (keylen_q == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;

    // Store read ports; indices outside the store (including round 15) return zero.
    always_comb begin
        prev_s  = 128'h0;
        prev2_s = 128'h0;
        rk_s    = 128'h0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            prev_s  = (4'(i) == prev_idx_s)  ? keys_q[i] : prev_s;
            prev2_s = (4'(i) == prev2_idx_s) ? keys_q[i] : prev2_s;
            rk_s    = (4'(i) == bus.round)   ? keys_q[i] : rk_s;
        end
    end

    aes_key_step u_step (
        .prev      (prev_s),
        .prev2     (prev2_s),
        .new_sboxw (bus.new_sboxw),
        .rcon      (rcon_q),
        .keylen    (keylen_q),
        .odd_idx   (cnt_q[0]),
        .next_key  (next_key_s),
        .sboxw     (step_sboxw_s),
        .rot_sel   (rot_sel_s)
    );

    // The shared S-box only sees a live word while keys are being generated.
    assign bus.sboxw     = (state_q == ST_GEN) ? step_sboxw_s : 32'h0000_0000;
    assign bus.round_key = rk_s;
    assign bus.ready     = ready_q;

    // Next-state logic for the expansion FSM, counters, rcon and key store.
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        keylen_d = keylen_q;
        rcon_d   = rcon_q;
        cnt_d    = cnt_q;
        keys_d   = keys_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.init && ready_q) begin
                    state_d  = ST_INIT;
                    keylen_d = bus.keylen;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_INIT: begin
                keys_d[0] = bus.key[255:128];
                rcon_d    = RCON_INIT;
                state_d   = ST_GEN;
                if (keylen_q == AES_256_BIT_KEY) begin
                    keys_d[1] = bus.key[127:0];
                    cnt_d     = 4'd2;
                end else begin
                    cnt_d     = 4'd1;
                end
            end
            ST_GEN: begin
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (4'(i) == cnt_q) begin
                        keys_d[i] = next_key_s;
                    end else begin
                        keys_d[i] = keys_q[i];
                    end
                end
                rcon_d = rot_sel_s ? gm2(rcon_q) : rcon_q;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == last_idx_s) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    state_d = ST_GEN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State registers; reset aborts any expansion and clears the store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            keylen_q <= AES_128_BIT_KEY;
            rcon_q   <= RCON_INIT;
            cnt_q    <= 4'd0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                keys_q[i] <= 128'h0;
            end
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            keylen_q <= keylen_d;
            rcon_q   <= rcon_d;
            cnt_q    <= cnt_d;
            keys_q   <= keys_d;
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander against a word-level FIPS-197 schedule model.
module tb_aes_key_expander;

    logic clk = 1'b0;
    logic reset;

    aes_key_expander_if bus ();

    aes_key_expander dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox [256];
    logic [127:0] exp_rk [15];

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    // Forward S-box from GF(2^8) inversion plus the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] r1, r2, r3, r4;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
            sbox[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    always_comb bus.new_sboxw = subword(bus.sboxw);

    // FIPS-197 word-wise key schedule.
    task automatic expand_model(input logic [255:0] k, input logic kl);
        int nk = kl ? 8 : 4;
        int nr = kl ? 14 : 10;
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = subword({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                temp = subword(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r < 15; r++)
            exp_rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Pulse init, then count cycles with ready low; optionally inject a second init mid-run.
    task automatic run_expansion(input logic [255:0] k, input logic kl, input bit no_wait,
                                 input int inject_at, input logic [255:0] k2,
                                 output int low_cycles);
        if (!no_wait) @(negedge clk);
        bus.key = k; bus.keylen = kl; bus.init = 1'b1;
        @(posedge clk); #1 bus.init = 1'b0;
        low_cycles = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            bus.init = 1'b0;
            if (bus.ready === 1'b1) break;
            low_cycles++;
            if (low_cycles == inject_at) begin
                bus.init = 1'b1; bus.key = k2; bus.keylen = ~kl;
            end
        end
        bus.init = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        n_checks++;
        if (bus.sboxw !== 32'h0) begin n_fail++; $display("FAIL reset_sboxw: got %h expected 0", bus.sboxw); end
        for (int r = 0; r < 16; r++) begin
            bus.round = 4'(r); #1;
            n_checks++;
            if (bus.round_key !== 128'h0) begin
                n_fail++; $display("FAIL reset_rk[%0d]: got %h expected 0", r, bus.round_key);
            end
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_aes128_vector();
        int low;
        run_expansion(KEY128, 1'b0, 1'b0, 0, 256'h0, low);
        n_checks++;
        if (low !== 11) begin n_fail++; $display("FAIL aes128_latency: got %0d expected 11", low); end
        expand_model(KEY128, 1'b0);
        bus.round = 4'd1; #1; n_checks++;
        if (bus.round_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            n_fail++; $display("FAIL aes128_rk1: got %h expected a0fafe1788542cb123a339392a6c7605", bus.round_key);
        end
        bus.round = 4'd10; #1; n_checks++;
        if (bus.round_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_fail++; $display("FAIL aes128_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", bus.round_key);
        end
        for (int r = 0; r <= 10; r++) begin
            bus.round = 4'(r); #1; n_checks++;
            if (bus.round_key !== exp_rk[r]) begin
                n_fail++; $display("FAIL aes128_rk[%0d]: got %h expected %h", r, bus.round_key, exp_rk[r]);
            end
        end
    endtask

    task automatic test_aes256_vector();
        int low;
        run_expansion(KEY256, 1'b1, 1'b0, 0, 256'h0, low);
        n_checks++;
        if (low !== 14) begin n_fail++; $display("FAIL aes256_latency: got %0d expected 14", low); end
        expand_model(KEY256, 1'b1);
        bus.round = 4'd2; #1; n_checks++;
        if (bus.round_key !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin
            n_fail++; $display("FAIL aes256_rk2: got %h expected 9ba354118e6925afa51a8b5f2067fcde", bus.round_key);
        end
        bus.round = 4'd14; #1; n_checks++;
        if (bus.round_key !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            n_fail++; $display("FAIL aes256_rk14: got %h expected fe4890d1e6188d0b046df344706c631e", bus.round_key);
        end
        for (int r = 0; r <= 14; r++) begin
            bus.round = 4'(r); #1; n_checks++;
            if (bus.round_key !== exp_rk[r]) begin
                n_fail++; $display("FAIL aes256_rk[%0d]: got %h expected %h", r, bus.round_key, exp_rk[r]);
            end
        end
    endtask

    task automatic test_init_ignored();
        int low;
        logic [255:0] ka = rand256();
        run_expansion(ka, 1'b0, 1'b0, 5, rand256(), low);
        n_checks++;
        if (low !== 11) begin n_fail++; $display("FAIL busy_init_latency: got %0d expected 11", low); end
        expand_model(ka, 1'b0);
        for (int r = 0; r <= 10; r++) begin
            bus.round = 4'(r); #1; n_checks++;
            if (bus.round_key !== exp_rk[r]) begin
                n_fail++; $display("FAIL busy_init_rk[%0d]: got %h expected %h", r, bus.round_key, exp_rk[r]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int low;
        logic [255:0] k = rand256();
        @(negedge clk);
        bus.key = rand256(); bus.keylen = 1'b1; bus.init = 1'b1;
        @(posedge clk); #1 bus.init = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1; #1;
        n_checks++;
        if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b expected 1", bus.ready); end
        n_checks++;
        if (bus.sboxw !== 32'h0) begin n_fail++; $display("FAIL midreset_sboxw: got %h expected 0", bus.sboxw); end
        for (int r = 0; r < 15; r++) begin
            bus.round = 4'(r); #1; n_checks++;
            if (bus.round_key !== 128'h0) begin
                n_fail++; $display("FAIL midreset_rk[%0d]: got %h expected 0", r, bus.round_key);
            end
        end
        @(negedge clk); reset = 1'b0;
        run_expansion(k, 1'b1, 1'b0, 0, 256'h0, low);
        n_checks++;
        if (low !== 14) begin n_fail++; $display("FAIL postreset_latency: got %0d expected 14", low); end
        expand_model(k, 1'b1);
        for (int r = 0; r <= 14; r++) begin
            bus.round = 4'(r); #1; n_checks++;
            if (bus.round_key !== exp_rk[r]) begin
                n_fail++; $display("FAIL postreset_rk[%0d]: got %h expected %h", r, bus.round_key, exp_rk[r]);
            end
        end
    endtask

    task automatic test_idle_outputs();
        bus.round = 4'd15; #1; n_checks++;
        if (bus.round_key !== 128'h0) begin n_fail++; $display("FAIL round15: got %h expected 0", bus.round_key); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); n_checks++;
            if (bus.sboxw !== 32'h0 || bus.ready !== 1'b1) begin
                n_fail++; $display("FAIL idle_outputs: got sboxw=%h ready=%b expected sboxw=0 ready=1", bus.sboxw, bus.ready);
            end
        end
    endtask

    // Init held during the last busy cycle must be dropped; the next cycle's init is taken.
    task automatic test_back_to_back();
        int low;
        run_expansion(rand256(), 1'b1, 1'b0, 14, rand256(), low);
        n_checks++;
        if (low !== 14) begin n_fail++; $display("FAIL b2b_aes256_latency: got %0d expected 14", low); end
        run_expansion(KEY128, 1'b0, 1'b1, 0, 256'h0, low);
        n_checks++;
        if (low !== 11) begin n_fail++; $display("FAIL b2b_aes128_latency: got %0d expected 11", low); end
        expand_model(KEY128, 1'b0);
        for (int r = 0; r <= 10; r++) begin
            bus.round = 4'(r); #1; n_checks++;
            if (bus.round_key !== exp_rk[r]) begin
                n_fail++; $display("FAIL b2b_rk[%0d]: got %h expected %h", r, bus.round_key, exp_rk[r]);
            end
        end
    endtask

    task automatic test_random();
        int low;
        for (int n = 0; n < 6; n++) begin
            logic [255:0] k = rand256();
            logic kl = 1'(n % 2);
            run_expansion(k, kl, 1'b0, 0, 256'h0, low);
            n_checks++;
            if (low !== (kl ? 14 : 11)) begin
                n_fail++; $display("FAIL rand_latency: got %0d expected %0d", low, kl ? 14 : 11);
            end
            expand_model(k, kl);
            for (int r = 0; r <= (kl ? 14 : 10); r++) begin
                bus.round = 4'(r); #1; n_checks++;
                if (bus.round_key !== exp_rk[r]) begin
                    n_fail++; $display("FAIL rand_rk[%0d]: got %h expected %h", r, bus.round_key, exp_rk[r]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.key = 256'h0; bus.keylen = 1'b0; bus.init = 1'b0; bus.round = 4'd0;
        build_sbox();
        test_reset();
        test_aes128_vector();
        test_aes256_vector();
        test_init_ignored();
        test_reset_mid();
        test_idle_outputs();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
Upstream companion to the decipher round block. It expands a 128- or 256-bit cipher key into all round keys, one round key per cycle, and stores them in an internal 15 x 128-bit key store. The decipher/encipher datapath reads the store combinationally by round index. It shares one forward S-box word lookup with the encipher datapath through the sboxw/new_sboxw port pair.

Parameters:
NUM_KEYS, 15, depth of the round-key store (rk0..rk14); fixed by AES-256, not to be reduced.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
key  input  256  cipher key; AES-128 uses key[255:128], key[127:0] ignored
keylen  input  1  0 = AES-128, 1 = AES-256; sampled only when init is accepted
init  input  1  start expansion; single-cycle pulse, honoured only when ready=1
round  input  4  round-key index requested by datapath
round_key  output  128  key store entry [round], combinational
ready  output  1  1 = store valid and idle, 0 = expansion in progress
sboxw  output  32  word sent to shared forward S-box
new_sboxw  input  32  S-box result, same-cycle combinational return

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: all key store entries 0, ready=1, FSM=IDLE, rcon=8'h01, round counter 0, keylen register 0. Outputs: round_key=0, sboxw=0.
- FSM states:
  - IDLE: on init, go to INIT. Latch keylen, clear ready at the same edge.
  - INIT (1 cycle):
    - AES-128: write rk0 = key[255:128].
    - AES-256: write rk0 = key[255:128] and rk1 = key[127:0].
    - Set rcon=01 and the key counter to the next index (1 or 2). Go to GEN.
  - GEN: write one key per cycle at the counter index, then increment the counter.
    - After writing index 10 (AES-128) or 14 (AES-256): go to IDLE and set ready=1 at that edge.
- Latency, with init sampled at edge E0:
  - AES-128: rk1..rk10 written at E2..E11; ready=1 after E11 (11 cycles low).
  - AES-256: rk2..rk14 written at E2..E14; ready=1 after E14 (14 cycles low).
- Key step, with prev = last written key, prev2 = key two back (AES-256), t = prev word3:
  - AES-128: temp = SubWord(RotWord(t)) ^ {rcon,24'h0}. Then w0 = prev.w0 ^ temp and wi = w(i-1) ^ prev.wi. rcon = gm2(rcon) after use.
  - AES-256, even index: temp = SubWord(RotWord(t)) ^ {rcon,24'h0}, chained onto prev2 the same way; rcon advances.
  - AES-256, odd index: temp = SubWord(t), with no rotate and no rcon; chained onto prev2; rcon unchanged.
  - rcon sequence: 01,02,04,08,10,20,40,80,1b,36; gm2 reduction uses polynomial 8'h1b.
- sboxw drives the required word only in GEN; it is 0 otherwise, so the shared S-box mux stays quiescent.
- round_key: round > 14 returns 128'h0. Entries beyond the active key length keep stale or zero content and are not guaranteed.
- Boundary conditions:
  - init while ready=0: ignored; expansion continues unchanged.
  - init in the same cycle ready rises: not accepted. Accepted from the following cycle.
  - reset mid-expansion: immediate abort, store cleared, ready=1.
  - key/keylen changes during expansion: no effect. Key words are consumed only in INIT, keylen from its latched copy.
  - Reads during expansion: return current store content. Entries not yet written are stale.

Decomposition:
- Shared package aes_pkg holds: AES_128_BIT_KEY / AES_256_BIT_KEY, AES128_ROUNDS = 4'ha, AES256_ROUNDS = 4'he, FSM state encodings, the gm2 function and initial RCON = 8'h01.
- One sub-module, aes_key_step: combinational next-key computation.
  - Inputs: prev, prev2, new_sboxw, rcon, keylen, index parity.
  - Outputs: next key and sboxw select.
- The top level keeps the FSM, counters, rcon register and key store.

Test Plan:
- AES-128 vector, key[255:128]=2b7e151628aed2a6abf7158809cf4f3c, init pulse:
  - ready low 11 cycles;
  - round=1 gives a0fafe1788542cb123a339392a6c7605;
  - round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-256 vector, key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, keylen=1:
  - ready low 14 cycles;
  - round=2 gives 9ba354118e6925afa51a8b5f2067fcde;
  - round=14 gives fe4890d1e6188d0b046df344706c631e.
- init pulsed again at cycle 5 of an expansion, with a different key: ignored; final keys match the first key, ready timing unchanged.
- reset asserted at cycle 6 of an AES-256 expansion: ready=1 and round_key=0 for every index immediately. A following init produces correct keys.
- round=15 after any expansion -> round_key=0. In IDLE, sboxw=0 in every cycle.
- Back-to-back: AES-256 expansion, then AES-128 expansion started the cycle after ready rises -> rk0..rk10 hold AES-128 values; rcon restarts at 01 (rk1 matches the vector).
